// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
//   Shared definitions for the RV32I multi-cycle sequencing controller:
//   - opcode constants for the eight supported instruction classes
//   - the controller state enumeration (also exported on the debug bus)
//   - ALUOp encodings and error codes
//   - is_legal_op(): true for the opcodes the controller can sequence
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] U_TYPE = 7'b0110111;  // LUI
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JR     = 7'b1100111;  // JALR
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd5
  } ctrl_state_e;

  localparam logic [1:0] ALUOP_ADD = 2'b00;  // LW/SW address, jump target
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RI  = 2'b10;  // R-type / I-type arithmetic
  localparam logic [1:0] ALUOP_LUI = 2'b11;  // pass immediate

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JR, JAL: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//   Bundles the controller's datapath/memory-facing signals.
//   Handshake: MemReq is held high by the controller for the whole access;
//   the access completes in the cycle where MemReq && MemReady are both high
//   (same-cycle completion). MemReady in a cycle without MemReq is ignored.
//   modport master : the controller (drives control, consumes Opcode etc.)
//   modport slave  : datapath + memory side
//   Signals:
//     Opcode[6:0], MemReady, BrTaken                 -> controller
//     MemReq, IorD, MemRead, MemWrite, IRWrite,
//     PCWrite, ALUSrc, ALUOp[1:0], Branch, JSel,
//     JalrSel, MemtoReg, RWSel, RegWrite, Retire     <- controller
//     InstRet[CNT_W-1:0], Err, ErrCode[1:0]          <- controller status
//     DbgState[2:0]                                  <- current FSM state
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 32
) ();

  logic [6:0]       Opcode;
  logic             MemReady;
  logic             BrTaken;

  logic             MemReq;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             Branch;
  logic             JSel;
  logic             JalrSel;
  logic             MemtoReg;
  logic             RWSel;
  logic             RegWrite;
  logic             Retire;
  logic [CNT_W-1:0] InstRet;
  logic             Err;
  logic [1:0]       ErrCode;
  logic [2:0]       DbgState;

  modport master (
    input  Opcode, MemReady, BrTaken,
    output MemReq, IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, ALUOp,
           Branch, JSel, JalrSel, MemtoReg, RWSel, RegWrite, Retire,
           InstRet, Err, ErrCode, DbgState
  );

  modport slave (
    output Opcode, MemReady, BrTaken,
    input  MemReq, IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, ALUOp,
           Branch, JSel, JalrSel, MemtoReg, RWSel, RegWrite, Retire,
           InstRet, Err, ErrCode, DbgState
  );

endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts consecutive cycles in which a memory request is stalled.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     i_wait      : request outstanding and not acknowledged this cycle
//     i_clear     : FSM is changing state this cycle
//     o_expire    : this is the MEM_TIMEOUT-th consecutive stalled cycle
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // r_count holds the number of stalled cycles already seen, so the current
  // stalled cycle is number r_count+1.
  assign o_expire = i_wait && (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || !i_wait) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over a
//   single shared memory port and emits per-state datapath control.
//   Ports:
//     clk    : clock, all state on rising edge
//     reset  : asynchronous, active-high; FSM to FETCH, all outputs forced 0
//     bus    : multicycle_controller_if.master (control, handshake, status)
//   Parameters:
//     MEM_TIMEOUT : stalled-request cycles tolerated before ERROR (>=1)
//     CNT_W       : retired-instruction counter width
// -----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next_state;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_instret;

  logic w_is_r, w_is_i, w_is_u, w_is_lw, w_is_sw, w_is_br, w_is_jr, w_is_jal;
  logic w_is_jump;
  logic w_wait, w_clear, w_expire;

  logic       w_mem_req, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_pc_write, w_alu_src, w_branch, w_jsel, w_jalr_sel;
  logic       w_mem_to_reg, w_rw_sel, w_reg_write, w_retire;
  logic [1:0] w_alu_op;

  assign w_is_r    = (bus.Opcode == R_TYPE);
  assign w_is_i    = (bus.Opcode == I_TYPE);
  assign w_is_u    = (bus.Opcode == U_TYPE);
  assign w_is_lw   = (bus.Opcode == LW);
  assign w_is_sw   = (bus.Opcode == SW);
  assign w_is_br   = (bus.Opcode == BR);
  assign w_is_jr   = (bus.Opcode == JR);
  assign w_is_jal  = (bus.Opcode == JAL);
  assign w_is_jump = w_is_jal || w_is_jr;

  // Timer only advances while a request is stalled; any state change
  // (including the move to ERROR) restarts it.
  assign w_wait  = w_mem_req && !bus.MemReady;
  assign w_clear = (w_next_state != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_wait   (w_wait),
    .i_clear  (w_clear),
    .o_expire (w_expire)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (bus.MemReady)  w_next_state = DECODE;
        else if (w_expire) w_next_state = ERROR;
      end
      DECODE: begin
        w_next_state = is_legal_op(bus.Opcode) ? EXEC : ERROR;
      end
      EXEC: begin
        if (w_is_br)                  w_next_state = FETCH;
        else if (w_is_lw || w_is_sw)  w_next_state = MEM;
        else                          w_next_state = WB;
      end
      MEM: begin
        // Only LW/SW reach MEM; anything that is not a load retires here.
        if (bus.MemReady)  w_next_state = w_is_lw ? WB : FETCH;
        else if (w_expire) w_next_state = ERROR;
      end
      WB:      w_next_state = FETCH;
      ERROR:   w_next_state = ERROR;
      default: w_next_state = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Gated by reset so an in-flight request drops as soon as
  // reset asserts rather than at the next clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mem_req    = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_branch     = 1'b0;
    w_jsel       = 1'b0;
    w_jalr_sel   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_rw_sel     = 1'b0;
    w_reg_write  = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          w_mem_req  = 1'b1;
          w_mem_read = 1'b1;
          w_ir_write = bus.MemReady;
        end
        EXEC: begin
          w_alu_src = w_is_lw || w_is_sw || w_is_i || w_is_u;
          if (w_is_br)                w_alu_op = ALUOP_BR;
          else if (w_is_r || w_is_i)  w_alu_op = ALUOP_RI;
          else if (w_is_u)            w_alu_op = ALUOP_LUI;
          w_jsel     = w_is_jump;
          w_jalr_sel = w_is_jr;
          // Branch retires here; BrTaken steers the PC mux in the datapath.
          w_branch   = w_is_br;
          w_pc_write = w_is_br;
        end
        MEM: begin
          w_mem_req   = 1'b1;
          w_iord      = 1'b1;
          w_mem_read  = w_is_lw;
          w_mem_write = w_is_sw;
          w_pc_write  = !w_is_lw && bus.MemReady;
        end
        WB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = w_is_lw;
          w_rw_sel     = w_is_jump;
          w_jsel       = w_is_jump;
          w_jalr_sel   = w_is_jr;
          w_pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_retire = w_pc_write;

  // ---------------------------------------------------------------------------
  // Status: error code captured on entry to ERROR, retired counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_code <= ERR_NONE;
    end else if (r_state != ERROR && w_next_state == ERROR) begin
      r_err_code <= (r_state == DECODE) ? ERR_ILLEGAL : ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign bus.MemReq   = w_mem_req;
  assign bus.IorD     = w_iord;
  assign bus.MemRead  = w_mem_read;
  assign bus.MemWrite = w_mem_write;
  assign bus.IRWrite  = w_ir_write;
  assign bus.PCWrite  = w_pc_write;
  assign bus.ALUSrc   = w_alu_src;
  assign bus.ALUOp    = w_alu_op;
  assign bus.Branch   = w_branch;
  assign bus.JSel     = w_jsel;
  assign bus.JalrSel  = w_jalr_sel;
  assign bus.MemtoReg = w_mem_to_reg;
  assign bus.RWSel    = w_rw_sel;
  assign bus.RegWrite = w_reg_write;
  assign bus.Retire   = w_retire;
  assign bus.InstRet  = r_instret;
  assign bus.Err      = (r_state == ERROR);
  assign bus.ErrCode  = r_err_code;
  assign bus.DbgState = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Drives instruction sequences (opcode, fetch/data wait counts, BrTaken)
//   into the controller acting as memory + IR. For every instruction the
//   expected outcome (latency, control signals seen, counter value, or error
//   code) is pushed into exp_q; a negedge monitor pops one entry per Retire or
//   first Err cycle and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_U   = 7'b0110111;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // Per-instruction "was ever asserted" flags
  localparam logic [7:0] F_REGW  = 8'h80;
  localparam logic [7:0] F_M2R   = 8'h40;
  localparam logic [7:0] F_RWSEL = 8'h20;
  localparam logic [7:0] F_JSEL  = 8'h10;
  localparam logic [7:0] F_JALR  = 8'h08;
  localparam logic [7:0] F_BR    = 8'h04;
  localparam logic [7:0] F_MEMW  = 8'h02;
  localparam logic [7:0] F_DREAD = 8'h01;

  typedef struct packed {
    logic          is_err;
    logic [1:0]    code;
    logic [7:0]    lat;
    logic [7:0]    flags;
    logic [CW-1:0] ret_before;
    logic [1:0]    aluop;
    logic          alusrc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [6:0] legal_ops [8] = '{OPC_R, OPC_I, OPC_U, OPC_LW, OPC_SW, OPC_BR, OPC_JR, OPC_JAL};

  logic clk = 1'b0;
  logic reset;
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int model_ret = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CW)) bus_if ();

  multicycle_controller #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic [15:0] ctrl_vec();
    return {bus_if.MemReq, bus_if.IorD, bus_if.MemRead, bus_if.MemWrite,
            bus_if.IRWrite, bus_if.PCWrite, bus_if.ALUSrc, bus_if.ALUOp,
            bus_if.Branch, bus_if.JSel, bus_if.JalrSel, bus_if.MemtoReg,
            bus_if.RWSel, bus_if.RegWrite, bus_if.Retire};
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: instruction class -> cycles, controls seen, ALU setup
  // ---------------------------------------------------------------------------
  function automatic exp_t model_ok(input logic [6:0] op, input int wf, input int wm);
    exp_t e;
    int   cycles;
    e = '0;
    cycles = 4;
    case (op)
      OPC_BR:  begin cycles = 3;      e.flags = F_BR;                       e.aluop = 2'b01; end
      OPC_LW:  begin cycles = 5 + wm; e.flags = F_REGW | F_M2R | F_DREAD;   e.alusrc = 1'b1; end
      OPC_SW:  begin cycles = 4 + wm; e.flags = F_MEMW;                     e.alusrc = 1'b1; end
      OPC_R:   begin                  e.flags = F_REGW;                     e.aluop = 2'b10; end
      OPC_I:   begin                  e.flags = F_REGW; e.aluop = 2'b10;    e.alusrc = 1'b1; end
      OPC_U:   begin                  e.flags = F_REGW; e.aluop = 2'b11;    e.alusrc = 1'b1; end
      OPC_JAL: begin                  e.flags = F_REGW | F_RWSEL | F_JSEL;                   end
      default: begin                  e.flags = F_REGW | F_RWSEL | F_JSEL | F_JALR;          end
    endcase
    e.lat        = 8'(cycles + wf);
    e.ret_before = CW'(model_ret);
    return e;
  endfunction

  function automatic exp_t model_err(input logic [1:0] code, input int lat);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.code   = code;
    e.lat    = 8'(lat);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic rdy, input logic br);
    bus_if.MemReady = rdy;
    bus_if.BrTaken  = br;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.MemReady = 1'b0;
    bus_if.BrTaken  = 1'b0;
    #1;
    check("rst_ctrl_zero", ctrl_vec(), 16'h0);
    check("rst_instret", bus_if.InstRet, 0);
    check("rst_err", {bus_if.Err, bus_if.ErrCode}, 3'b000);
    check("q_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 0;
    #1;
    check("fetch_after_rst", {bus_if.MemReq, bus_if.MemRead, bus_if.IorD}, 3'b110);
  endtask

  task automatic fetch(input int wf);
    for (int i = 0; i < wf; i++) cyc(1'b0, rb());
    cyc(1'b1, rb());
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic brt);
    exp_q.push_back(model_ok(op, wf, wm));
    fetch(wf);
    bus_if.Opcode = op;
    cyc(rb(), rb());                          // DECODE
    cyc(rb(), brt);                           // EXEC
    if (op == OPC_LW || op == OPC_SW) begin
      for (int i = 0; i < wm; i++) cyc(1'b0, rb());
      cyc(1'b1, rb());
    end
    if (op != OPC_BR && op != OPC_SW) cyc(rb(), rb());  // WB
    model_ret = (model_ret + 1) % (1 << CW);
  endtask

  task automatic run_illegal(input logic [6:0] op, input int wf);
    exp_q.push_back(model_err(2'b01, wf + 3));
    fetch(wf);
    bus_if.Opcode = op;
    cyc(rb(), rb());                          // DECODE
    for (int i = 0; i < 4; i++) cyc(rb(), rb());
    do_reset();
  endtask

  task automatic run_fetch_timeout();
    exp_q.push_back(model_err(2'b10, TMO + 1));
    for (int i = 0; i < TMO; i++) cyc(1'b0, rb());
    for (int i = 0; i < 4; i++) cyc(rb(), rb());
    do_reset();
  endtask

  task automatic run_mem_timeout(input int wf);
    exp_q.push_back(model_err(2'b10, wf + 3 + TMO + 1));
    fetch(wf);
    bus_if.Opcode = OPC_LW;
    cyc(rb(), rb());
    cyc(rb(), rb());
    for (int i = 0; i < TMO; i++) cyc(1'b0, rb());
    for (int i = 0; i < 4; i++) cyc(rb(), rb());
    do_reset();
  endtask

  task automatic run_sw_abort(input int wf);
    fetch(wf);
    bus_if.Opcode = OPC_SW;
    cyc(rb(), rb());
    cyc(rb(), rb());
    bus_if.MemReady = 1'b0;                   // first MEM cycle, stalled
    #2;
    check("abort_pre", {bus_if.MemReq, bus_if.IorD, bus_if.MemWrite}, 3'b111);
    reset = 1'b1;
    #1;
    check("abort_drop", {bus_if.MemReq, bus_if.MemWrite}, 2'b00);
    check("abort_instret", bus_if.InstRet, 0);
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int         mon_cyc;
  int         mon_ir_at;
  int         mon_irw;
  int         mon_pcw;
  logic [7:0] mon_flags;
  logic       mon_err_seen;
  logic [1:0] mon_err_code;
  logic [1:0] mon_aluop;
  logic       mon_alusrc;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (reset) begin
      mon_cyc = 0; mon_ir_at = 0; mon_irw = 0; mon_pcw = 0;
      mon_flags = '0; mon_err_seen = 1'b0; mon_aluop = '0; mon_alusrc = 1'b0;
    end else if (mon_err_seen) begin
      check("err_ctrl_zero", ctrl_vec(), 16'h0);
      check("err_status", {bus_if.Err, bus_if.ErrCode}, {1'b1, mon_err_code});
    end else begin
      mon_cyc++;
      mon_flags |= {bus_if.RegWrite, bus_if.MemtoReg, bus_if.RWSel, bus_if.JSel,
                    bus_if.JalrSel, bus_if.Branch, bus_if.MemWrite,
                    bus_if.MemRead && bus_if.IorD};
      if (bus_if.IRWrite) begin mon_irw++; mon_ir_at = mon_cyc; end
      if (bus_if.PCWrite) mon_pcw++;
      if (mon_ir_at != 0 && mon_cyc == mon_ir_at + 2) begin
        mon_aluop  = bus_if.ALUOp;
        mon_alusrc = bus_if.ALUSrc;
      end
      check("rd_wr_exclusive", bus_if.MemRead && bus_if.MemWrite, 0);
      check("pcw_irw_exclusive", bus_if.PCWrite && bus_if.IRWrite, 0);
      check("retire_with_pcw", bus_if.Retire, bus_if.PCWrite);
      if (bus_if.Retire || bus_if.Err) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_event: retire=%0b err=%0b, expected none (t=%0t)",
                   bus_if.Retire, bus_if.Err, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", bus_if.Err, mon_e.is_err);
          check("latency", mon_cyc, mon_e.lat);
          if (mon_e.is_err) begin
            check("err_code", bus_if.ErrCode, mon_e.code);
            check("err_ctrl_zero", ctrl_vec(), 16'h0);
            mon_err_seen = 1'b1;
            mon_err_code = mon_e.code;
          end else begin
            check("ctrl_flags", mon_flags, mon_e.flags);
            check("irwrite_count", mon_irw, 1);
            check("pcwrite_count", mon_pcw, 1);
            check("instret", bus_if.InstRet, mon_e.ret_before);
            check("exec_aluop", mon_aluop, mon_e.aluop);
            check("exec_alusrc", mon_alusrc, mon_e.alusrc);
          end
        end
        mon_cyc = 0; mon_ir_at = 0; mon_irw = 0; mon_pcw = 0; mon_flags = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [6:0] op;
    reset = 1'b1;
    bus_if.Opcode   = 7'h00;
    bus_if.MemReady = 1'b0;
    bus_if.BrTaken  = 1'b0;
    do_reset();

    // addi with zero-wait memory
    run_instr(OPC_I, 0, 0, 1'b0);
    check("instret_after_addi", bus_if.InstRet, 1);
    // lw with three data wait cycles
    run_instr(OPC_LW, 0, 3, 1'b0);
    // branch taken then not taken
    run_instr(OPC_BR, 0, 0, 1'b1);
    run_instr(OPC_BR, 1, 0, 1'b0);
    // every class at zero wait and at the largest wait that avoids timeout
    foreach (legal_ops[k]) begin
      run_instr(legal_ops[k], 0, 0, rb());
      run_instr(legal_ops[k], TMO - 1, TMO - 1, rb());
    end

    run_illegal(7'b1111111, 0);
    run_fetch_timeout();
    run_mem_timeout(1);

    run_instr(OPC_R, 0, 0, 1'b0);
    run_instr(OPC_SW, 1, 0, 1'b0);
    run_sw_abort(1);

    // random mix; enough retirements to wrap the counter several times
    for (int i = 0; i < 60; i++) begin
      run_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1), rb());
    end
    check("instret_wrapped", bus_if.InstRet, model_ret);

    do op = 7'($urandom_range(0, 127)); while (is_legal(op));
    run_illegal(op, $urandom_range(0, TMO - 1));

    run_instr(OPC_JAL, 0, 0, 1'b0);
    run_instr(OPC_JR, 2, 0, 1'b0);
    check("instret_final", bus_if.InstRet, model_ret);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
